// File: rtl/tnew_scoreboard_pkg.sv
// Shared constants for the D-stage hazard logic: forward-select encodings,
// slot indices, default mult/div latencies and the Tuse/Tnew encodings.
package tnew_scoreboard_pkg;

  localparam int FWD_RF       = 0;
  localparam int SLOT_E       = 1;
  localparam int SLOT_M       = 2;
  localparam int SLOT_W       = 3;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

  // Tuse: how many cycles after D the operand is first consumed
  localparam logic [1:0] TUSE_D    = 2'd0;
  localparam logic [1:0] TUSE_E    = 2'd1;
  localparam logic [1:0] TUSE_M    = 2'd2;

  // Tnew on entry to E: cycles until the result can be forwarded
  localparam logic [1:0] TNEW_NONE = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tnew_scoreboard_md_busy_counter.sv
// Mult/div busy timer: loads a latency on start, counts down to zero and holds.
import tnew_scoreboard_pkg::*;

module md_busy_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_busy
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/tnew_scoreboard.sv
// D-stage hazard scoreboard: ages {dst, Tnew} of in-flight instructions and
// derives stall and forward selects from the youngest matching producer.
import tnew_scoreboard_pkg::*;

module tnew_scoreboard #(
  parameter int STAGES   = 3,
  parameter int REG_AW   = 5,
  parameter int TNEW_W   = 2,
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          d_valid,
  input  logic [REG_AW-1:0]             d_rs,
  input  logic [REG_AW-1:0]             d_rt,
  input  logic [TNEW_W-1:0]             d_tuse_rs,
  input  logic [TNEW_W-1:0]             d_tuse_rt,
  input  logic [REG_AW-1:0]             d_dst,
  input  logic [TNEW_W-1:0]             d_tnew,
  input  logic                          d_md_start,
  input  logic                          d_md_is_div,
  input  logic                          d_md_use,
  output logic                          stall,
  output logic [$clog2(STAGES+1)-1:0]   fwd_rs_sel,
  output logic [$clog2(STAGES+1)-1:0]   fwd_rt_sel,
  output logic                          md_busy
);

  localparam int FWD_W = $clog2(STAGES + 1);
  localparam int MD_W  = $clog2(max_int(MULT_LAT, DIV_LAT) + 1);

  logic [REG_AW-1:0] r_dst  [SLOT_E:STAGES];
  logic [TNEW_W-1:0] r_tnew [SLOT_E:STAGES];

  logic [STAGES:SLOT_E] w_hit_rs;
  logic [STAGES:SLOT_E] w_hit_rt;
  logic                 w_stall_rs;
  logic                 w_stall_rt;
  logic                 w_md_stall;
  logic                 w_md_busy;
  logic                 w_stall;
  logic                 w_issue;
  logic                 w_md_load;
  logic [MD_W-1:0]      w_md_val;
  logic [FWD_W-1:0]     w_fwd_rs;
  logic [FWD_W-1:0]     w_fwd_rt;

  // Register 0 is hardwired, so a write to it never creates a dependency
  for (genvar gi = SLOT_E; gi <= STAGES; gi++) begin : g_hit
    assign w_hit_rs[gi] = (d_rs != '0) && (r_dst[gi] == d_rs);
    assign w_hit_rt[gi] = (d_rt != '0) && (r_dst[gi] == d_rt);
  end

  // Walk oldest to youngest so the youngest match overwrites older ones
  always_comb begin
    w_stall_rs = 1'b0;
    w_stall_rt = 1'b0;
    w_fwd_rs   = FWD_W'(FWD_RF);
    w_fwd_rt   = FWD_W'(FWD_RF);
    for (int i = STAGES; i >= SLOT_E; i--) begin
      if (w_hit_rs[i]) begin
        w_stall_rs = d_valid && (r_tnew[i] > d_tuse_rs);
        w_fwd_rs   = (r_tnew[i] == '0) ? FWD_W'(i) : FWD_W'(FWD_RF);
      end
      if (w_hit_rt[i]) begin
        w_stall_rt = d_valid && (r_tnew[i] > d_tuse_rt);
        w_fwd_rt   = (r_tnew[i] == '0) ? FWD_W'(i) : FWD_W'(FWD_RF);
      end
    end
  end

  assign w_md_stall = d_valid && d_md_use && w_md_busy;
  assign w_stall    = w_stall_rs || w_stall_rt || w_md_stall;
  assign w_issue    = d_valid && !w_stall;
  assign w_md_load  = w_issue && d_md_start;
  assign w_md_val   = d_md_is_div ? MD_W'(DIV_LAT) : MD_W'(MULT_LAT);

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = SLOT_E; i <= STAGES; i++) begin
        r_dst[i]  <= '0;
        r_tnew[i] <= '0;
      end
    end else begin
      r_dst[SLOT_E]  <= w_issue ? d_dst  : '0;
      r_tnew[SLOT_E] <= w_issue ? d_tnew : '0;
      for (int i = SLOT_E + 1; i <= STAGES; i++) begin
        r_dst[i]  <= r_dst[i-1];
        r_tnew[i] <= (r_tnew[i-1] == '0) ? '0 : r_tnew[i-1] - 1'b1;
      end
    end
  end

  md_busy_counter #(
    .W (MD_W)
  ) u_md_busy_counter (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_md_load),
    .i_load_val (w_md_val),
    .o_busy     (w_md_busy)
  );

  assign stall      = w_stall;
  assign fwd_rs_sel = w_fwd_rs;
  assign fwd_rt_sel = w_fwd_rt;
  assign md_busy    = w_md_busy;

endmodule

// File: tb/tb_tnew_scoreboard.sv
// Bench for tnew_scoreboard: directed vector table, mult/div and reset
// sequences, then random traffic against an instruction-history model.
module tb_tnew_scoreboard;

  localparam int NS   = 3;
  localparam int MULT = 5;
  localparam int DIV  = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       d_valid;
  logic [4:0] d_rs, d_rt, d_dst;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_md_start, d_md_is_div, d_md_use;
  logic       stall, md_busy;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;

  always #5 clk = ~clk;

  tnew_scoreboard dut (
    .clk         (clk),
    .reset       (reset),
    .d_valid     (d_valid),
    .d_rs        (d_rs),
    .d_rt        (d_rt),
    .d_tuse_rs   (d_tuse_rs),
    .d_tuse_rt   (d_tuse_rt),
    .d_dst       (d_dst),
    .d_tnew      (d_tnew),
    .d_md_start  (d_md_start),
    .d_md_is_div (d_md_is_div),
    .d_md_use    (d_md_use),
    .stall       (stall),
    .fwd_rs_sel  (fwd_rs_sel),
    .fwd_rt_sel  (fwd_rt_sel),
    .md_busy     (md_busy)
  );

  typedef struct {
    logic       rst;
    logic       v;
    logic [4:0] rs, rt, dst;
    logic [1:0] tu_rs, tu_rt, tnew;
    logic       md_start, md_div, md_use;
    logic       e_stall;
    logic [1:0] e_rs, e_rt;
    logic       e_busy;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  bit last_stall;

  // Model: h_*[i] is what was issued i cycles ago (bubble = dst 0)
  int h_dst  [1:NS];
  int h_tnew [1:NS];
  int cyc     = 0;
  int md_free = 0;

  function automatic vec_t mk(input logic v, input int rs, input int tu_rs,
                              input int rt, input int tu_rt, input int dst,
                              input int tnew, input logic e_stall,
                              input int e_rs, input int e_rt);
    vec_t t;
    t.rst = 1'b1; t.v = v;
    t.rs = 5'(rs); t.tu_rs = 2'(tu_rs); t.rt = 5'(rt); t.tu_rt = 2'(tu_rt);
    t.dst = 5'(dst); t.tnew = 2'(tnew);
    t.md_start = 1'b0; t.md_div = 1'b0; t.md_use = 1'b0;
    t.e_stall = e_stall; t.e_rs = 2'(e_rs); t.e_rt = 2'(e_rt); t.e_busy = 1'b0;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 1; i <= NS; i++) begin
      h_dst[i]  = 0;
      h_tnew[i] = 0;
    end
    md_free = 0;
  endfunction

  function automatic void look(input int r, input int tuse, output int sel, output bit st);
    int eff;
    sel = 0;
    st  = 1'b0;
    if (r == 0) return;
    for (int i = 1; i <= NS; i++) begin
      if (h_dst[i] == r) begin
        eff = h_tnew[i] - (i - 1);
        if (eff < 0) eff = 0;
        sel = (eff == 0) ? i : 0;
        st  = (eff > tuse);
        return;
      end
    end
  endfunction

  task automatic apply(input vec_t t, input bit tab_chk, input string nm);
    int  mrs, mrt;
    bit  srs, srt, mb, ms;
    reset = t.rst; d_valid = t.v;
    d_rs = t.rs; d_rt = t.rt; d_tuse_rs = t.tu_rs; d_tuse_rt = t.tu_rt;
    d_dst = t.dst; d_tnew = t.tnew;
    d_md_start = t.md_start; d_md_is_div = t.md_div; d_md_use = t.md_use;
    @(negedge clk);
    look(int'(t.rs), int'(t.tu_rs), mrs, srs);
    look(int'(t.rt), int'(t.tu_rt), mrt, srt);
    mb = (cyc < md_free);
    ms = t.v && (srs || srt || (t.md_use && mb));
    last_stall = stall;
    chk({nm, "_stall"},  8'(stall),      8'(ms));
    chk({nm, "_fwd_rs"}, 8'(fwd_rs_sel), 8'(mrs));
    chk({nm, "_fwd_rt"}, 8'(fwd_rt_sel), 8'(mrt));
    chk({nm, "_busy"},   8'(md_busy),    8'(mb));
    if (tab_chk) begin
      chk({nm, "_tab_stall"},  8'(stall),      8'(t.e_stall));
      chk({nm, "_tab_fwd_rs"}, 8'(fwd_rs_sel), 8'(t.e_rs));
      chk({nm, "_tab_fwd_rt"}, 8'(fwd_rt_sel), 8'(t.e_rt));
      chk({nm, "_tab_busy"},   8'(md_busy),    8'(t.e_busy));
    end
    @(posedge clk);
    if (!t.rst) begin
      model_clear();
    end else begin
      for (int i = NS; i > 1; i--) begin
        h_dst[i]  = h_dst[i-1];
        h_tnew[i] = h_tnew[i-1];
      end
      h_dst[1]  = (t.v && !ms) ? int'(t.dst)  : 0;
      h_tnew[1] = (t.v && !ms) ? int'(t.tnew) : 0;
      if (t.v && t.md_start && !ms) md_free = cyc + 1 + (t.md_div ? DIV : MULT);
    end
    cyc++;
    #1;
  endtask

  task automatic run_md(input bit is_div, input int lat, input string nm);
    vec_t st, use_v;
    int   n;
    st = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    st.md_start = 1'b1; st.md_div = is_div; st.md_use = 1'b1;
    use_v = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    use_v.md_use = 1'b1;
    apply(st, 1'b1, {nm, "_start"});
    n = 0;
    for (int k = 0; k < lat + 5; k++) begin
      apply(use_v, 1'b0, {nm, "_use"});
      if (!last_stall) break;
      n++;
    end
    chk({nm, "_stall_cycles"}, 8'(n), 8'(lat));
  endtask

  vec_t tab [14];
  vec_t t;

  initial begin
    // scenario rows: lw/add, addu/beq, $0 producer, youngest-match, slot-3 forward
    tab[0]  = mk(1, 1, 0, 2, 0, 0, 0, 0, 0, 0);
    tab[0].md_use = 1'b1;
    tab[1]  = mk(1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    tab[2]  = mk(1, 1, 1, 0, 0, 4, 1, 1, 0, 0);
    tab[3]  = mk(1, 1, 1, 0, 0, 4, 1, 0, 0, 0);
    tab[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tab[5]  = mk(1, 0, 0, 0, 0, 2, 1, 0, 0, 0);
    tab[6]  = mk(1, 2, 0, 0, 0, 0, 0, 1, 0, 0);
    tab[7]  = mk(1, 2, 0, 0, 0, 0, 0, 0, 2, 0);
    tab[8]  = mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tab[9]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tab[10] = mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    tab[11] = mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    tab[12] = mk(1, 3, 0, 0, 0, 0, 0, 1, 0, 0);
    tab[13] = mk(1, 3, 0, 0, 0, 0, 0, 0, 2, 0);

    reset = 1'b0; d_valid = 1'b0; d_rs = '0; d_rt = '0; d_dst = '0;
    d_tuse_rs = '0; d_tuse_rt = '0; d_tnew = '0;
    d_md_start = 1'b0; d_md_is_div = 1'b0; d_md_use = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) apply(tab[i], 1'b1, $sformatf("vec%0d", i));
    apply(mk(1, 0, 0, 3, 0, 0, 0, 0, 0, 3), 1'b1, "slot3_rt");

    run_md(1'b0, MULT, "mult");
    run_md(1'b1, DIV, "div");

    // reset in the middle of an MD stall with a live producer in the slots
    apply(mk(1, 0, 0, 0, 0, 7, 2, 0, 0, 0), 1'b0, "rst_prod");
    t = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    t.md_start = 1'b1; t.md_use = 1'b1;
    apply(t, 1'b0, "rst_mult");
    t = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    t.md_use = 1'b1;
    apply(t, 1'b0, "rst_pre");
    t.rst = 1'b0;
    apply(t, 1'b0, "rst_cycle");
    t = mk(1, 7, 0, 7, 0, 0, 0, 0, 0, 0);
    t.md_use = 1'b1;
    apply(t, 1'b1, "rst_after");

    for (int n = 0; n < 800; n++) begin
      t = mk(($urandom_range(0, 4) != 0), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), 0, 0, 0);
      t.rst      = ($urandom_range(0, 63) != 0);
      t.md_start = ($urandom_range(0, 15) == 0);
      t.md_div   = $urandom_range(0, 1);
      t.md_use   = t.md_start || ($urandom_range(0, 3) == 0);
      apply(t, 1'b0, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
